pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard/stall-flush controller for the 5-stage pipeline (IF/ID/EXE/MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the IF/ID/EXE/MEM/WB pipeline.
// Provides issue-interval ring gating, register-0 filtered hazard matching,
// load-use and branch-operand hazards, and a data-memory wait handshake with a
// sticky watchdog flag.
// Optional feature macro: HAZARD_STATS_EN builds the STALL_CNT/MEMWAIT_CNT
// statistics counters; when undefined both outputs are tied to zero.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W          = 5,
    parameter int unsigned ISSUE_INTERVAL = 5,
    parameter int unsigned MEM_TIMEOUT    = 15,
    parameter int unsigned STAT_W         = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              ID_Jump_IN,
    input  logic              ID_Branch_IN,
    input  logic [REG_W-1:0]  ID_RegRS_IN,
    input  logic [REG_W-1:0]  ID_RegRT_IN,
    input  logic [REG_W-1:0]  IDEXE_WriteReg_IN,
    input  logic              IDEXE_WriteEn_IN,
    input  logic              IDEXE_MemRead_IN,
    input  logic [REG_W-1:0]  EXEMEM_WriteReg_IN,
    input  logic              EXEMEM_MemRead_IN,
    input  logic              EXEMEM_MemAcc_IN,
    input  logic              MEM_Ready_IN,
    output logic              STALL_IFID,
    output logic              FLUSH_IFID,
    output logic              STALL_IDEXE,
    output logic              FLUSH_IDEXE,
    output logic              STALL_EXEMEM,
    output logic              FLUSH_EXEMEM,
    output logic              STALL_MEMWB,
    output logic              FLUSH_MEMWB,
    output logic              ISSUE_SLOT,
    output logic              MEM_TIMEOUT_ERR,
    output logic [STAT_W-1:0] STALL_CNT,
    output logic [STAT_W-1:0] MEMWAIT_CNT
);

    localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [ISSUE_INTERVAL-1:0] ring_q, ring_d, ring_rot_c;
    logic [WD_W-1:0]           wd_q, wd_d, wd_inc_c;
    logic                      err_q, err_d, err_set_c;
    logic                      memwait_c, hazard_c, gate_c;
    logic                      match_ie_c, match_em_c, loaduse_c, brhaz_c;
    logic                      stall_ifid_c, flush_ifid_c, stall_idexe_c, flush_idexe_c;
    logic                      stall_exemem_c, flush_exemem_c, stall_memwb_c, flush_memwb_c;

    // Register match that ignores register 0 (hard-wired zero never carries a dependency).
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    // Hazard and wait conditions, evaluated in the current cycle.
    always_comb begin
        match_ie_c = reg_match(IDEXE_WriteReg_IN, ID_RegRS_IN) | reg_match(IDEXE_WriteReg_IN, ID_RegRT_IN);
        match_em_c = reg_match(EXEMEM_WriteReg_IN, ID_RegRS_IN) | reg_match(EXEMEM_WriteReg_IN, ID_RegRT_IN);
        memwait_c  = EXEMEM_MemAcc_IN & ~MEM_Ready_IN;
        loaduse_c  = IDEXE_MemRead_IN & IDEXE_WriteEn_IN & match_ie_c;
        brhaz_c    = (ID_Jump_IN | ID_Branch_IN) &
                     ((IDEXE_WriteEn_IN & match_ie_c) | (EXEMEM_MemRead_IN & match_em_c));
        hazard_c   = loaduse_c | brhaz_c;
        gate_c     = (ISSUE_INTERVAL > 1) && !ring_q[0];
    end

    // Left rotation of the issue ring; a single-slot ring never changes.
    generate
        if (ISSUE_INTERVAL > 1) begin : g_ring_rot
            assign ring_rot_c = {ring_q[ISSUE_INTERVAL-2:0], ring_q[ISSUE_INTERVAL-1]};
        end else begin : g_ring_fixed
            assign ring_rot_c = ring_q;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stay in MEMWAIT until the memory reports ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (memwait_c)  state_d = ST_MEMWAIT;
            ST_MEMWAIT: if (!memwait_c) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // FSM outputs: memory wait dominates hazards, which dominate issue gating.
    always_comb begin
        stall_ifid_c   = 1'b0;
        flush_ifid_c   = 1'b0;
        stall_idexe_c  = 1'b0;
        flush_idexe_c  = 1'b0;
        stall_exemem_c = 1'b0;
        flush_exemem_c = 1'b0;
        stall_memwb_c  = 1'b0;
        flush_memwb_c  = 1'b0;
        if (memwait_c) begin
            stall_ifid_c   = 1'b1;
            stall_idexe_c  = 1'b1;
            stall_exemem_c = 1'b1;
            flush_memwb_c  = 1'b1;
        end else if (hazard_c) begin
            stall_ifid_c  = 1'b1;
            flush_idexe_c = 1'b1;
        end else if (gate_c) begin
            stall_ifid_c = 1'b1;
            flush_ifid_c = 1'b1;
        end
    end

    // Ring and watchdog next state; both hold or restart around memory waits.
    always_comb begin
        ring_d    = memwait_c ? ring_q : ring_rot_c;
        wd_inc_c  = WD_W'(1);
        if (state_q == ST_MEMWAIT) begin
            wd_inc_c = (wd_q == WD_W'(MEM_TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
        end
        wd_d      = memwait_c ? wd_inc_c : '0;
        err_set_c = memwait_c && (wd_inc_c == WD_W'(MEM_TIMEOUT));
        err_d     = err_q | err_set_c;
    end

    // Ring, watchdog and sticky error registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ring_q <= ISSUE_INTERVAL'(1);
            wd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            ring_q <= ring_d;
            wd_q   <= wd_d;
            err_q  <= err_d;
        end
    end

    assign STALL_IFID      = stall_ifid_c   & ~RESET;
    assign FLUSH_IFID      = flush_ifid_c   & ~RESET;
    assign STALL_IDEXE     = stall_idexe_c  & ~RESET;
    assign FLUSH_IDEXE     = flush_idexe_c  & ~RESET;
    assign STALL_EXEMEM    = stall_exemem_c & ~RESET;
    assign FLUSH_EXEMEM    = flush_exemem_c & ~RESET;
    assign STALL_MEMWB     = stall_memwb_c  & ~RESET;
    assign FLUSH_MEMWB     = flush_memwb_c  & ~RESET;
    assign ISSUE_SLOT      = ring_q[0];
    assign MEM_TIMEOUT_ERR = (err_q | err_set_c) & ~RESET;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    // Statistics next state: hazard cycles and memory-wait cycles, wrapping.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (memwait_c) begin
            memwait_cnt_d = memwait_cnt_q + STAT_W'(1);
        end else if (hazard_c) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign STALL_CNT   = stall_cnt_q;
    assign MEMWAIT_CNT = memwait_cnt_q;
`else
    assign STALL_CNT   = '0;
    assign MEMWAIT_CNT = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (issue interval 5 and 1) share
// the same stimulus; a cycle model pushes expected outputs to a scoreboard that
// is popped and compared on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO    = 15;
    localparam int unsigned OBS_W = 148;

    typedef struct packed {
        logic       r;
        logic       j;
        logic       b;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] iew;
        logic       iewe;
        logic       iemr;
        logic [4:0] emw;
        logic       emr;
        logic       ema;
        logic       rdy;
    } stim_t;

    localparam stim_t IDLE = '0;

    logic       clk = 1'b0;
    logic       rst, jump, branch, iewe, iemr, emr, ema, rdy;
    logic [4:0] rs, rt, iew, emw;
    wire  [7:0] c5, c1;
    wire        s5, s1, e5, e1;
    wire [31:0] sc5, mc5, sc1, mc1;

    int unsigned      vecs = 0;
    int unsigned      miss = 0;
    logic [OBS_W-1:0] sb[$];

    int          ph5   = 0;
    int unsigned m_wd  = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_sc  = '0;
    logic [31:0] m_mc  = '0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(5), .ISSUE_INTERVAL(5), .MEM_TIMEOUT(TO), .STAT_W(32)) u_dut5 (
        .CLOCK(clk), .RESET(rst), .ID_Jump_IN(jump), .ID_Branch_IN(branch),
        .ID_RegRS_IN(rs), .ID_RegRT_IN(rt), .IDEXE_WriteReg_IN(iew),
        .IDEXE_WriteEn_IN(iewe), .IDEXE_MemRead_IN(iemr), .EXEMEM_WriteReg_IN(emw),
        .EXEMEM_MemRead_IN(emr), .EXEMEM_MemAcc_IN(ema), .MEM_Ready_IN(rdy),
        .STALL_IFID(c5[7]), .FLUSH_IFID(c5[6]), .STALL_IDEXE(c5[5]), .FLUSH_IDEXE(c5[4]),
        .STALL_EXEMEM(c5[3]), .FLUSH_EXEMEM(c5[2]), .STALL_MEMWB(c5[1]), .FLUSH_MEMWB(c5[0]),
        .ISSUE_SLOT(s5), .MEM_TIMEOUT_ERR(e5), .STALL_CNT(sc5), .MEMWAIT_CNT(mc5));

    pipeline_hazard_ctrl #(.REG_W(5), .ISSUE_INTERVAL(1), .MEM_TIMEOUT(TO), .STAT_W(32)) u_dut1 (
        .CLOCK(clk), .RESET(rst), .ID_Jump_IN(jump), .ID_Branch_IN(branch),
        .ID_RegRS_IN(rs), .ID_RegRT_IN(rt), .IDEXE_WriteReg_IN(iew),
        .IDEXE_WriteEn_IN(iewe), .IDEXE_MemRead_IN(iemr), .EXEMEM_WriteReg_IN(emw),
        .EXEMEM_MemRead_IN(emr), .EXEMEM_MemAcc_IN(ema), .MEM_Ready_IN(rdy),
        .STALL_IFID(c1[7]), .FLUSH_IFID(c1[6]), .STALL_IDEXE(c1[5]), .FLUSH_IDEXE(c1[4]),
        .STALL_EXEMEM(c1[3]), .FLUSH_EXEMEM(c1[2]), .STALL_MEMWB(c1[1]), .FLUSH_MEMWB(c1[0]),
        .ISSUE_SLOT(s1), .MEM_TIMEOUT_ERR(e1), .STALL_CNT(sc1), .MEMWAIT_CNT(mc1));

    function automatic stim_t st(input logic r_, input logic j_, input logic b_,
                                 input logic [4:0] rs_, input logic [4:0] rt_,
                                 input logic [4:0] iew_, input logic iewe_, input logic iemr_,
                                 input logic [4:0] emw_, input logic emr_,
                                 input logic ema_, input logic rdy_);
        stim_t s;
        s = '{r: r_, j: j_, b: b_, rs: rs_, rt: rt_, iew: iew_, iewe: iewe_, iemr: iemr_,
              emw: emw_, emr: emr_, ema: ema_, rdy: rdy_};
        return s;
    endfunction

    // {memory wait, hazard} for the inputs currently applied
    function automatic logic [1:0] conds();
        logic mie, mem, mw, hz;
        mie = (iew != 5'd0) && ((iew == rs) || (iew == rt));
        mem = (emw != 5'd0) && ((emw == rs) || (emw == rt));
        mw  = ema && !rdy;
        hz  = (iemr && iewe && mie) || ((jump || branch) && ((iewe && mie) || (emr && mem)));
        return {mw, hz};
    endfunction

    function automatic logic [7:0] ctl(input logic mw, input logic hz, input logic gt);
        if (mw) return 8'b1010_1001;
        if (hz) return 8'b1001_0000;
        if (gt) return 8'b1100_0000;
        return 8'h00;
    endfunction

    function automatic logic [OBS_W-1:0] model_eval();
        logic [1:0] c;
        logic       er;
        if (rst) return {8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 128'h0};
        c  = conds();
        er = m_err || (c[1] && (m_wd + 1 >= TO));
        return {ctl(c[1], c[0], ph5 != 0), ph5 == 0, er,
                ctl(c[1], c[0], 1'b0), 1'b1, er, m_sc, m_mc, m_sc, m_mc};
    endfunction

    task automatic model_commit();
        logic [1:0] c;
        if (rst) begin
            ph5 = 0; m_wd = 0; m_err = 1'b0; m_sc = '0; m_mc = '0;
            return;
        end
        c = conds();
        if (c[1] && (m_wd + 1 >= TO)) m_err = 1'b1;
        if (c[1]) m_wd = (m_wd + 1 > TO) ? TO : m_wd + 1;
        else      m_wd = 0;
        if (!c[1]) ph5 = (ph5 + 1) % 5;
`ifdef HAZARD_STATS_EN
        if (c[1])      m_mc = m_mc + 32'd1;
        else if (c[0]) m_sc = m_sc + 32'd1;
`endif
    endtask

    function automatic logic [OBS_W-1:0] observed();
        return {c5, s5, e5, c1, s1, e1, sc5, mc5, sc1, mc1};
    endfunction

    task automatic drive(input stim_t s);
        rst = s.r; jump = s.j; branch = s.b; rs = s.rs; rt = s.rt;
        iew = s.iew; iewe = s.iewe; iemr = s.iemr; emw = s.emw;
        emr = s.emr; ema = s.ema; rdy = s.rdy;
        sb.push_back(model_eval());
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        stim_t v[$];
        logic [OBS_W-1:0] exp;
        v.push_back(st(1, 1, 0, 5'd3, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 0));
        v.push_back(st(1, 0, 1, 5'd4, 5'd0, 5'd4, 1, 1, 5'd0, 0, 0, 1));
        v.push_back(st(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL reset cyc %0d: got %h expected %h", i, observed(), exp);
            end
            tick();
        end
    endtask

    task automatic test_issue_ring();
        logic [OBS_W-1:0] exp;
        int slots = 0;
        for (int i = 0; i < 10; i++) begin
            drive(IDLE);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL issue_ring cyc %0d: got %h expected %h", i, observed(), exp);
            end
            if (s5) slots++;
            tick();
        end
        vecs++;
        if (slots != 2) begin
            miss++;
            $display("FAIL issue_ring_slots: got %0d expected 2", slots);
        end
    endtask

    task automatic test_load_use();
        stim_t v[$];
        logic [OBS_W-1:0] exp;
        v.push_back(st(0, 0, 0, 5'd8, 5'd2, 5'd8, 1, 1, 5'd0, 0, 0, 0));
        v.push_back(IDLE);
        v.push_back(st(0, 0, 0, 5'd1, 5'd8, 5'd8, 1, 1, 5'd0, 0, 0, 0));
        v.push_back(st(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0));
        v.push_back(st(0, 0, 0, 5'd8, 5'd8, 5'd8, 1, 0, 5'd0, 0, 0, 0));
        v.push_back(st(0, 0, 0, 5'd8, 5'd8, 5'd8, 0, 1, 5'd0, 0, 0, 0));
        v.push_back(IDLE);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL load_use cyc %0d: got %h expected %h", i, observed(), exp);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        stim_t v[$];
        logic [OBS_W-1:0] exp;
        v.push_back(st(0, 0, 1, 5'd0, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0));
        v.push_back(st(0, 0, 1, 5'd4, 5'd9, 5'd0, 0, 0, 5'd9, 1, 0, 0));
        v.push_back(st(0, 1, 0, 5'd7, 5'd0, 5'd7, 1, 0, 5'd0, 0, 0, 0));
        v.push_back(st(0, 0, 1, 5'd4, 5'd9, 5'd0, 0, 0, 5'd9, 0, 0, 0));
        v.push_back(st(0, 0, 0, 5'd4, 5'd9, 5'd9, 1, 0, 5'd9, 1, 0, 0));
        v.push_back(IDLE);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL branch cyc %0d: got %h expected %h", i, observed(), exp);
            end
            tick();
        end
    endtask

    task automatic test_memwait();
        stim_t v[$];
        logic [OBS_W-1:0] exp;
        logic [31:0] mc0, sc0;
        mc0 = mc5;
        sc0 = sc5;
        for (int i = 0; i < 3; i++) v.push_back(st(0, 0, 0, 5'd8, 5'd0, 5'd8, 1, 1, 5'd3, 1, 1, 0));
        v.push_back(st(0, 0, 0, 5'd8, 5'd0, 5'd8, 1, 1, 5'd3, 1, 1, 1));
        v.push_back(IDLE);
        v.push_back(IDLE);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL memwait cyc %0d: got %h expected %h", i, observed(), exp);
            end
            tick();
        end
`ifdef HAZARD_STATS_EN
        vecs++;
        if ((mc5 - mc0 !== 32'd3) || (sc5 - sc0 !== 32'd1)) begin
            miss++;
            $display("FAIL memwait_stats: got mw %0d st %0d expected mw 3 st 1", mc5 - mc0, sc5 - sc0);
        end
`else
        vecs++;
        if ((mc5 !== mc0) || (sc5 !== sc0) || (mc5 !== 32'd0)) begin
            miss++;
            $display("FAIL memwait_stats_off: got mw %0d st %0d expected 0 0", mc5, sc5);
        end
`endif
    endtask

    task automatic test_timeout();
        stim_t v[$];
        logic [OBS_W-1:0] exp;
        for (int i = 0; i < 20; i++) v.push_back(st(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0));
        v.push_back(st(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1));
        v.push_back(IDLE);
        v.push_back(IDLE);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL timeout cyc %0d: got %h expected %h", i, observed(), exp);
            end
            if (i == 13 || i == 14 || i == 22) begin
                vecs++;
                if (e5 !== (i != 13)) begin
                    miss++;
                    $display("FAIL timeout_err cyc %0d: got %b expected %b", i, e5, i != 13);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        stim_t v[$];
        logic [OBS_W-1:0] exp;
        v.push_back(st(0, 0, 0, 5'd6, 5'd0, 5'd6, 1, 1, 5'd0, 0, 0, 0));
        for (int i = 0; i < 3; i++) v.push_back(st(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0));
        v.push_back(st(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0));
        for (int i = 0; i < 4; i++) v.push_back(IDLE);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL reset_midrun cyc %0d: got %h expected %h", i, observed(), exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        logic [OBS_W-1:0] exp;
        for (int i = 0; i < 300; i++) begin
            s = st($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
            drive(s);
            @(negedge clk);
            exp = sb.pop_front();
            vecs++;
            if (observed() !== exp) begin
                miss++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", i, observed(), exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_issue_ring();
        test_load_use();
        test_branch();
        test_memwait();
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
